// File: rtl/alu_writeback_stage_if.sv
// alu_writeback_stage_if: ALU-to-writeback and writeback-to-regfile handshake bundle
interface alu_writeback_stage_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_result;
   logic              in_carry;
   logic              in_zero;
   logic [REG_AW-1:0] in_rd;
   logic [1:0]        in_cond;
   logic              in_wr_c;
   logic              in_wr_z;
   logic              out_valid;
   logic              out_ready;
   logic              out_wr_en;
   logic [REG_AW-1:0] out_rd;
   logic [DATA_W-1:0] out_data;
   modport master (
      output in_valid, in_result, in_carry, in_zero, in_rd, in_cond, in_wr_c, in_wr_z, out_ready,
      input  in_ready, out_valid, out_wr_en, out_rd, out_data
   );
   modport slave (
      input  in_valid, in_result, in_carry, in_zero, in_rd, in_cond, in_wr_c, in_wr_z, out_ready,
      output in_ready, out_valid, out_wr_en, out_rd, out_data
   );
endinterface

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registers the ALU result, owns C/Z flags and squashes failed conditional ops.
// Defining ALU_WB_PERF_EN adds saturating perf_commit/perf_squash counters.
module alu_writeback_stage #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   alu_writeback_stage_if.slave bus,
   output logic c_flag,
   output logic z_flag
`ifdef ALU_WB_PERF_EN
   ,
   output logic [15:0] perf_commit,
   output logic [15:0] perf_squash
`endif
);
   logic              valid_q;
   logic              wr_en_q;
   logic [REG_AW-1:0] rd_q;
   logic [DATA_W-1:0] data_q;
   logic              accept;
   logic              met;
   assign bus.in_ready  = !valid_q || bus.out_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_wr_en = wr_en_q;
   assign bus.out_rd    = rd_q;
   assign bus.out_data  = data_q;
   assign accept = bus.in_valid && bus.in_ready && !flush;
   // flags already include every earlier accepted op, so dependants need no bypass
   assign met = (bus.in_cond == 2'b00) || (bus.in_cond == 2'b10 && c_flag) ||
                (bus.in_cond == 2'b01 && z_flag);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         wr_en_q <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         c_flag  <= 1'b0;
         z_flag  <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
         wr_en_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         wr_en_q <= met;
         rd_q    <= bus.in_rd;
         data_q  <= bus.in_result;
         if (met && bus.in_wr_c) c_flag <= bus.in_carry;
         if (met && bus.in_wr_z) z_flag <= bus.in_zero;
      end else if (valid_q && bus.out_ready) begin
         valid_q <= 1'b0;
         wr_en_q <= 1'b0;
      end
   end
`ifdef ALU_WB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_commit <= '0;
         perf_squash <= '0;
      end else if (accept) begin
         if (met && perf_commit != 16'hFFFF) perf_commit <= perf_commit + 16'd1;
         if (!met && perf_squash != 16'hFFFF) perf_squash <= perf_squash + 16'd1;
      end
   end
`endif
endmodule
